// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, combinational imem address, registered IF/ID slot with valid/ready.
// One instruction per cycle; the slot holds under back-pressure and is flushed for one cycle on redirect.
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [31:0]     fetch_count
);

  typedef struct packed {
    logic            valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } slot_t;

  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_plus4;
  logic [XLEN-1:0] redirect_tgt;
  slot_t           slot;
  logic            load;
  logic            handshake;

  assign fetch_pc_plus4 = fetch_pc + XLEN'(4);
  // Masking rather than slicing keeps every redirect_pc bit in use.
  assign redirect_tgt   = redirect_pc & ~XLEN'(3);
  assign load           = !slot.valid || out_ready;
  assign handshake      = slot.valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      slot.valid    <= 1'b0;
      slot.instr    <= NOP;
      slot.pc       <= '0;
      slot.pc_plus4 <= '0;
      fetch_count   <= '0;
    end else begin
      // A handshake coinciding with a redirect still counts: decode took it.
      if (handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_valid) begin
        fetch_pc   <= redirect_tgt;
        slot.valid <= 1'b0;
      end else if (load) begin
        slot.valid    <= 1'b1;
        slot.instr    <= imem_instr;
        slot.pc       <= fetch_pc;
        slot.pc_plus4 <= fetch_pc_plus4;
        fetch_pc      <= fetch_pc_plus4;
      end
    end
  end

  assign imem_addr    = fetch_pc;
  assign out_valid    = slot.valid;
  assign out_instr    = slot.instr;
  assign out_pc       = slot.pc;
  assign out_pc_plus4 = slot.pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: ROM model, slot scoreboard, directed scenarios, random traffic, PC wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_instr, out_pc, out_pc_plus4, fetch_count;
  logic        out_valid;

  logic        rst_w;
  logic [31:0] imem_addr_w, imem_instr_w, out_instr_w, out_pc_w, out_pc_plus4_w, fetch_count_w;
  logic        out_valid_w;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a >= 32'h100) return 32'h0;
    case (a[7:2])
      6'd0:    return 32'h0010_0093;
      6'd1:    return 32'h0020_0113;
      6'd2:    return 32'h0030_8193;
      6'd3:    return 32'h0011_0213;
      6'd16:   return 32'h0000_0013;
      default: return 32'hA000_0000 | {26'd0, a[7:2]};
    endcase
  endfunction

  always_comb imem_instr   = rom_word(imem_addr);
  always_comb imem_instr_w = rom_word(imem_addr_w);

  instruction_fetch dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w),
    .out_pc(out_pc_w), .out_pc_plus4(out_pc_plus4_w), .fetch_count(fetch_count_w)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc    = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_count = 32'h0;

  // Advance one clock: consume/predict around the edge, then compare after it.
  task automatic step();
    exp_t e;
    if (m_valid && out_ready && !rst) begin
      check("sb_nonempty", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hs_instr", out_instr, e.instr);
        check("hs_pc", out_pc, e.pc);
        check("hs_pc4", out_pc_plus4, e.pc_plus4);
      end
    end
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0;
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) m_count++;
      if (redirect_valid) begin
        if (m_valid && !out_ready) exp_q.delete();
        m_valid = 1'b0;
        m_pc    = {redirect_pc[31:2], 2'b00};
      end else if (!m_valid || out_ready) begin
        e.instr = rom_word(m_pc); e.pc = m_pc; e.pc_plus4 = m_pc + 32'd4;
        exp_q.push_back(e);
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    check("valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("imem_addr", imem_addr, m_pc);
    check("count", fetch_count, m_count);
    if (m_valid && exp_q.size() > 0) begin
      check("slot_pc", out_pc, exp_q[0].pc);
      check("slot_instr", out_instr, exp_q[0].instr);
    end
  endtask

  logic [31:0] held_pc, held_instr, held_cnt;

  initial begin
    rst = 1'b1; rst_w = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    repeat (3) step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'h13);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", out_pc, 32'h0);

    rst = 1'b0;
    step();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_instr", out_instr, 32'h0010_0093);
    check("first_pc", out_pc, 32'h0);
    check("first_pc4", out_pc_plus4, 32'h4);
    check("first_addr", imem_addr, 32'h4);

    out_ready = 1'b1;
    repeat (4) step();
    check("stream_count", fetch_count, 32'd4);

    out_ready = 1'b0;
    held_pc = out_pc; held_instr = out_instr; held_cnt = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", out_pc, held_pc);
      check("stall_instr", out_instr, held_instr);
      check("stall_cnt", fetch_count, held_cnt);
      check("stall_addr", imem_addr, held_pc + 32'd4);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", out_pc, held_pc + 32'd4);
    check("release_cnt", fetch_count, held_cnt + 32'd1);

    out_ready = 1'b0;
    held_cnt = fetch_count;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    check("rdr_valid", {31'd0, out_valid}, 32'd0);
    check("rdr_addr", imem_addr, 32'h40);
    check("rdr_cnt", fetch_count, held_cnt);
    redirect_valid = 1'b0;
    step();
    check("rdr_tgt_pc", out_pc, 32'h40);
    check("rdr_tgt_instr", out_instr, 32'h13);

    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h403;
    step();
    check("mis_addr", imem_addr, 32'h400);
    redirect_valid = 1'b0;
    step();
    check("oor_instr", out_instr, 32'h0);
    check("oor_pc", out_pc, 32'h400);

    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_pc = 32'h30;
    step();
    check("b2b_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_addr", imem_addr, 32'h30);
    redirect_valid = 1'b0;
    step();
    check("b2b_pc", out_pc, 32'h30);

    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    check("rst_rdr_addr", imem_addr, 32'h0);
    check("rst_rdr_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rdr_cnt", fetch_count, 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    step();
    check("rst_rdr_pc", out_pc, 32'h0);

    for (int i = 0; i < 300; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_pc = redirect_pc & 32'hFF;
      rst            = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0;

    rst_w = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_w = 1'b0;
    @(posedge clk); #1;
    check("wrap_pc", out_pc_w, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc_plus4_w, 32'h0);
    check("wrap_instr", out_instr_w, 32'h0);
    check("wrap_addr", imem_addr_w, 32'h0);
    @(posedge clk); #1;
    check("wrap_next_pc", out_pc_w, 32'h0);
    check("wrap_next_instr", out_instr_w, 32'h0010_0093);
    check("wrap_cnt", fetch_count_w, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
